// File: rtl/noc_local_ni.sv
// Local network interface between a core and a router port: credit-based TX with packet
// framing, and an RX FIFO that returns credits. Optional err_o status via NOC_NI_ERR_STATUS_EN.
module noc_local_ni #(
    parameter int unsigned CREDITS  = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_tx_valid_i,
    input  logic [15:0] core_tx_data_i,
    output logic        core_tx_ready_o,
    output logic        ni_valid_o,
    output logic [15:0] ni_data_o,
    input  logic        ni_credit_i,
    input  logic        ni_valid_i,
    input  logic [15:0] ni_data_i,
    output logic        ni_credit_o,
    output logic        core_rx_valid_o,
    output logic [15:0] core_rx_data_o,
    input  logic        core_rx_ready_i,
    output logic        tx_busy_o,
    output logic [1:0]  err_o
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {IDLE, PAYLOAD} tx_state_t;

    tx_state_t      state;
    logic [2:0]     remaining;
    logic [CW-1:0]  credits;
    logic           credits_full;
    logic           tx_accept;

    logic [15:0]    rx_mem [RX_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           rx_empty;
    logic           rx_full;
    logic           rx_pop;
    logic           rx_push;

    assign core_tx_ready_o = (credits != '0);
    assign tx_accept       = core_tx_valid_i && core_tx_ready_o;
    assign credits_full    = (credits == CW'(CREDITS));

    // Accept and credit return in the same cycle cancel; a return while full saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credits <= CW'(CREDITS);
        end else if (tx_accept && !ni_credit_i) begin
            credits <= credits - CW'(1);
        end else if (!tx_accept && ni_credit_i && !credits_full) begin
            credits <= credits + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ni_valid_o <= 1'b0;
            ni_data_o  <= '0;
        end else begin
            ni_valid_o <= tx_accept;
            if (tx_accept) begin
                ni_data_o <= core_tx_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            tx_busy_o <= 1'b0;
        end else if (tx_accept) begin
            case (state)
                IDLE: begin
                    if (core_tx_data_i[2:0] != 3'd0) begin
                        state     <= PAYLOAD;
                        remaining <= core_tx_data_i[2:0];
                        tx_busy_o <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    remaining <= remaining - 3'd1;
                    if (remaining == 3'd1) begin
                        state     <= IDLE;
                        tx_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign rx_empty        = (wr_ptr == rd_ptr);
    assign rx_full         = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_pop          = !rx_empty && core_rx_ready_i;
    assign rx_push         = ni_valid_i && (!rx_full || rx_pop);
    assign core_rx_valid_o = !rx_empty;
    assign core_rx_data_o  = rx_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr[AW-1:0]] <= ni_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ni_credit_o <= 1'b0;
        end else begin
            ni_credit_o <= rx_pop;
            if (rx_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef NOC_NI_ERR_STATUS_EN
    logic [1:0] err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            if (ni_credit_i && !tx_accept && credits_full) begin
                err_q[0] <= 1'b1;
            end
            if (ni_valid_i && rx_full && !rx_pop) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed self-checking bench for noc_local_ni; expected err_o follows NOC_NI_ERR_STATUS_EN.
module tb_noc_local_ni;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_tx_valid_i;
    logic [15:0] core_tx_data_i;
    logic        core_tx_ready_o;
    logic        ni_valid_o;
    logic [15:0] ni_data_o;
    logic        ni_credit_i;
    logic        ni_valid_i;
    logic [15:0] ni_data_i;
    logic        ni_credit_o;
    logic        core_rx_valid_o;
    logic [15:0] core_rx_data_o;
    logic        core_rx_ready_i;
    logic        tx_busy_o;
    logic [1:0]  err_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef NOC_NI_ERR_STATUS_EN
    localparam logic [1:0] ERR_CREDIT = 2'b01;
    localparam logic [1:0] ERR_RX     = 2'b10;
`else
    localparam logic [1:0] ERR_CREDIT = 2'b00;
    localparam logic [1:0] ERR_RX     = 2'b00;
`endif

    noc_local_ni #(.CREDITS(8), .RX_DEPTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .core_tx_valid_i (core_tx_valid_i),
        .core_tx_data_i  (core_tx_data_i),
        .core_tx_ready_o (core_tx_ready_o),
        .ni_valid_o      (ni_valid_o),
        .ni_data_o       (ni_data_o),
        .ni_credit_i     (ni_credit_i),
        .ni_valid_i      (ni_valid_i),
        .ni_data_i       (ni_data_i),
        .ni_credit_o     (ni_credit_o),
        .core_rx_valid_o (core_rx_valid_o),
        .core_rx_data_o  (core_rx_data_o),
        .core_rx_ready_i (core_rx_ready_i),
        .tx_busy_o       (tx_busy_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ni_valid"}, 32'(ni_valid_o), 32'd0);
        check({tag, "_ni_data"}, 32'(ni_data_o), 32'd0);
        check({tag, "_ni_credit"}, 32'(ni_credit_o), 32'd0);
        check({tag, "_busy"}, 32'(tx_busy_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_rx_valid"}, 32'(core_rx_valid_o), 32'd0);
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        core_tx_valid_i = 1'b0;
        core_tx_data_i  = '0;
        ni_credit_i     = 1'b0;
        ni_valid_i      = 1'b0;
        ni_data_i       = '0;
        core_rx_ready_i = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Sends n header-only flits; ready must stay high until the last one, then drop.
    task automatic drain_credits(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            if (core_tx_ready_o !== 1'b1) begin
                check({tag, "_early_ready"}, 32'(core_tx_ready_o), 32'd1);
            end
            core_tx_valid_i = 1'b1;
            core_tx_data_i  = 16'(16'h0100 + (i << 4));
            tick();
        end
        core_tx_valid_i = 1'b0;
        check({tag, "_ready_empty"}, 32'(core_tx_ready_o), 32'd0);
    endtask

    initial begin
        do_reset();
        check_reset_outputs("rst");
        tick();
        check("rst_ready", 32'(core_tx_ready_o), 32'd1);

        // Header with three payloads, no credit returns.
        core_tx_valid_i = 1'b1;
        core_tx_data_i  = 16'h1203;
        tick();
        check("pk_hdr_valid", 32'(ni_valid_o), 32'd1);
        check("pk_hdr_data", 32'(ni_data_o), 32'h1203);
        check("pk_hdr_busy", 32'(tx_busy_o), 32'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            core_tx_data_i = 16'(16'hB0B0 + i);
            tick();
            check("pk_pl_valid", 32'(ni_valid_o), 32'd1);
            check("pk_pl_data", 32'(ni_data_o), 32'(16'hB0B0 + i));
            check("pk_pl_busy", 32'(tx_busy_o), (i < 2) ? 32'd1 : 32'd0);
        end
        core_tx_valid_i = 1'b0;
        tick();
        check("pk_idle_valid", 32'(ni_valid_o), 32'd0);
        check("pk_hold_data", 32'(ni_data_o), 32'hB0B2);
        drain_credits(4, "pk_credits4");
        core_tx_valid_i = 1'b1;
        core_tx_data_i  = 16'hDEAD;
        tick();
        check("pk_blocked", 32'(ni_valid_o), 32'd0);
        core_tx_valid_i = 1'b0;

        // Eight single-flit packets, then one credit back.
        do_reset();
        tick();
        drain_credits(8, "sf");
        check("sf_last_data", 32'(ni_data_o), 32'h0170);
        ni_credit_i = 1'b1;
        tick();
        ni_credit_i = 1'b0;
        check("sf_ready_back", 32'(core_tx_ready_o), 32'd1);

        // Accept and credit return together at credits=1.
        core_tx_valid_i = 1'b1;
        core_tx_data_i  = 16'h0A00;
        ni_credit_i     = 1'b1;
        tick();
        ni_credit_i = 1'b0;
        check("same_valid", 32'(ni_valid_o), 32'd1);
        check("same_ready", 32'(core_tx_ready_o), 32'd1);
        core_tx_data_i = 16'h0A10;
        tick();
        core_tx_valid_i = 1'b0;
        check("same_now0", 32'(core_tx_ready_o), 32'd0);

        // Refill to full, then one extra credit saturates.
        ni_credit_i = 1'b1;
        for (int unsigned i = 0; i < 8; i++) tick();
        ni_credit_i = 1'b0;
        check("refill_err", 32'(err_o), 32'd0);
        ni_credit_i = 1'b1;
        tick();
        ni_credit_i = 1'b0;
        check("sat_err", 32'(err_o), 32'(ERR_CREDIT));
        drain_credits(8, "sat");

        // RX overflow and in-order drain with credit pulses.
        do_reset();
        tick();
        ni_valid_i = 1'b1;
        for (int unsigned i = 0; i < 9; i++) begin
            ni_data_i = 16'(16'hA000 + i);
            tick();
            if (i == 0) begin
                check("rx_fwft_valid", 32'(core_rx_valid_o), 32'd1);
                check("rx_fwft_data", 32'(core_rx_data_o), 32'hA000);
            end
            if (i == 7) check("rx_err_before", 32'(err_o), 32'd0);
        end
        ni_valid_i = 1'b0;
        check("rx_drop_err", 32'(err_o), 32'(ERR_RX));
        core_rx_ready_i = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            check("rx_pop_valid", 32'(core_rx_valid_o), 32'd1);
            check("rx_pop_data", 32'(core_rx_data_o), 32'(16'hA000 + i));
            tick();
            check("rx_credit_pulse", 32'(ni_credit_o), 32'd1);
        end
        check("rx_empty", 32'(core_rx_valid_o), 32'd0);
        tick();
        check("rx_empty_nopulse", 32'(ni_credit_o), 32'd0);

        // Write into empty FIFO with ready held high.
        ni_valid_i = 1'b1;
        ni_data_i  = 16'h5A5A;
        tick();
        ni_valid_i = 1'b0;
        check("rx_wr_empty_valid", 32'(core_rx_valid_o), 32'd1);
        check("rx_wr_empty_data", 32'(core_rx_data_o), 32'h5A5A);
        check("rx_wr_empty_nocredit", 32'(ni_credit_o), 32'd0);
        tick();
        check("rx_wr_empty_credit", 32'(ni_credit_o), 32'd1);
        core_rx_ready_i = 1'b0;

        // Reset in the middle of a five-payload packet.
        do_reset();
        tick();
        core_tx_valid_i = 1'b1;
        core_tx_data_i  = 16'h0005;
        tick();
        core_tx_data_i = 16'hC001;
        tick();
        core_tx_data_i = 16'hC002;
        tick();
        check("mid_busy", 32'(tx_busy_o), 32'd1);
        reset = 1'b0;
        tick();
        check_reset_outputs("mid");
        reset           = 1'b1;
        core_tx_valid_i = 1'b0;
        tick();
        check("mid_ready", 32'(core_tx_ready_o), 32'd1);
        check("mid_quiet", 32'(ni_valid_o), 32'd0);
        drain_credits(8, "mid");
        check("mid_idle", 32'(tx_busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_local_ni.md
NOC_LOCAL_NI -- requirements
Module: noc_local_ni

Interface
- REQ-001 SHALL have one clock; reset is synchronous and active-low.
- REQ-002 SHALL have port: clk  in  1  rising-edge clock.
- REQ-003 SHALL have port: reset  in  1  synchronous active-low reset.
- REQ-004 SHALL have port: core_tx_valid_i  in  1  core offers a TX flit.
- REQ-005 SHALL have port: core_tx_data_i  in  16  TX flit from core.
- REQ-006 SHALL have port: core_tx_ready_o  out  1  TX flit accepted this cycle when high with core_tx_valid_i.
- REQ-007 SHALL have port: ni_valid_o  out  1  flit valid toward router local input.
- REQ-008 SHALL have port: ni_data_o  out  16  flit toward router local input.
- REQ-009 SHALL have port: ni_credit_i  in  1  one-cycle credit pulse from router; one router buffer slot freed.
- REQ-010 SHALL have port: ni_valid_i  in  1  flit valid from router local output.
- REQ-011 SHALL have port: ni_data_i  in  16  flit from router local output.
- REQ-012 SHALL have port: ni_credit_o  out  1  one-cycle credit pulse to router; one RX slot freed.
- REQ-013 SHALL have port: core_rx_valid_o  out  1  RX flit available.
- REQ-014 SHALL have port: core_rx_data_o  out  16  RX head flit.
- REQ-015 SHALL have port: core_rx_ready_i  in  1  core pops RX flit.
- REQ-016 SHALL have port: tx_busy_o  out  1  TX packet in progress.
- REQ-017 SHALL have port: err_o  out  2  sticky errors; bit0 credit overflow, bit1 RX overflow.
- REQ-018 SHALL have parameter: CREDITS, default 8, router input buffer depth and initial credit count.
- REQ-019 SHALL have parameter: RX_DEPTH, default 8, RX FIFO depth, power of two.

Function
- REQ-020 SHALL define the TX accept condition as core_tx_valid_i and credit count > 0.
- REQ-021 SHALL drive core_tx_ready_o combinationally high exactly when credit count > 0.
- REQ-022 SHALL register each accepted flit onto ni_data_o and drive ni_valid_o high for exactly the next cycle; latency is 1 cycle, and ni_valid_o is 0 otherwise.
- REQ-023 SHALL hold ni_data_o at its last value when ni_valid_o is 0.
- REQ-024 SHALL keep a credit counter of width clog2(CREDITS+1) bits: -1 on accept, +1 on ni_credit_i, unchanged when both occur in the same cycle.
- REQ-025 SHALL saturate the credit counter at CREDITS when ni_credit_i arrives with the counter already at CREDITS and no accept, and SHALL set err_o[0].
- REQ-026 SHALL implement the TX FSM with states IDLE and PAYLOAD. In IDLE, an accepted flit is the header; header[2:0] is the payload count N.
- REQ-027 SHALL return to IDLE from IDLE when N=0; when N>0 it SHALL load a remaining counter with N and go to PAYLOAD.
- REQ-028 SHALL, in PAYLOAD, decrement the remaining counter on each accept and go to IDLE on the accept that brings it to 0.
- REQ-029 SHALL drive tx_busy_o high exactly in PAYLOAD.
- REQ-030 SHALL forward header and payload flits unmodified.
- REQ-031 SHALL write ni_data_i into the RX FIFO on ni_valid_i when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- REQ-032 SHALL drop ni_valid_i when the FIFO is full with no pop, and SHALL set err_o[1].
- REQ-033 SHALL drive core_rx_valid_o = FIFO not empty and core_rx_data_o = head entry (first-word fall-through).
- REQ-034 SHALL pop on core_rx_valid_o && core_rx_ready_i; core_rx_ready_i SHALL be ignored when empty.
- REQ-035 SHALL pulse ni_credit_o for one cycle, registered, in the cycle after each pop; back-to-back pops SHALL give back-to-back pulses.
- REQ-036 SHALL use read/write pointers of clog2(RX_DEPTH)+1 bits that wrap modulo 2*RX_DEPTH; full/empty SHALL derive from the MSB compare.
- REQ-037 SHALL allow simultaneous write and pop on an empty FIFO; the written flit becomes visible the next cycle.

Reset
- REQ-038 SHALL, while reset=0 at a clock edge, set: credits=CREDITS, FSM=IDLE, remaining=0, RX FIFO empty, ni_valid_o=0, ni_data_o=0, ni_credit_o=0, err_o=0, tx_busy_o=0.
- REQ-039 SHALL abandon a packet in progress when reset is applied mid-packet, with no further flits emitted.
- REQ-040 SHALL drive core_tx_ready_o=1 in the first cycle after reset release.

Configuration
- REQ-041 SHALL, when NOC_NI_ERR_STATUS_EN is defined, implement the err_o sticky bits per REQ-025/REQ-032, cleared only by reset.
- REQ-042 SHALL, when NOC_NI_ERR_STATUS_EN is undefined, tie err_o to 2'b00 and remove its logic; saturation and drop behaviour SHALL remain unchanged.

Verification
- REQ-043 SHALL cover: header 16'h1203 then 3 payload flits with no credit returns -> ni_valid_o on 4 consecutive cycles, each 1 cycle after accept; tx_busy_o high for 3 cycles; credits end at 4.
- REQ-044 SHALL cover: 8 single-flit packets (header[2:0]=0) with no credits -> core_tx_ready_o low after the 8th; one ni_credit_i pulse -> ready high next cycle.
- REQ-045 SHALL cover: accept and ni_credit_i in the same cycle at credits=1 -> credits stay 1.
- REQ-046 SHALL cover: ni_credit_i at credits=8 -> credits stay 8; err_o=2'b01 (with the macro), 2'b00 (without).
- REQ-047 SHALL cover: 9 RX flits with core_rx_ready_i=0 -> 9th dropped, err_o[1]=1; then pop 8 -> 8 ni_credit_o pulses, data in order.
- REQ-048 SHALL cover: reset low in the middle of a 5-payload packet -> all outputs at reset values the next cycle; credits=8.
